// File: rtl/path_step_generator.sv
// Head-position generator for the growing-path animation: walks a fixed six-segment
// path on a start pulse and publishes the head coordinate, segment index and status.
module path_step_generator #(
  parameter int BASE_DIV  = 138889,
  parameter int SLOW_MULT = 3
) (
  input  logic       sixp25MHz_clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       start,
  output logic [6:0] var_x,
  output logic [6:0] var_y,
  output logic [2:0] segment,
  output logic       busy,
  output logic       done,
  output logic       step_pulse
);

  localparam int TW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam int SW = (SLOW_MULT > 1) ? $clog2(SLOW_MULT) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(BASE_DIV - 1);
  localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_MULT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_LOAD, S_DONE} state_t;

  // Segment table: even segments move along y, odd segments along x.
  function automatic logic seg_is_y(input logic [2:0] seg);
    return ~seg[0];
  endfunction

  function automatic logic [6:0] seg_start_x(input logic [2:0] seg);
    case (seg)
      3'd0, 3'd1: return 7'd84;
      3'd2, 3'd3: return 7'd42;
      3'd4:       return 7'd63;
      3'd5:       return 7'd59;
      default:    return 7'd84;
    endcase
  endfunction

  function automatic logic [6:0] seg_start_y(input logic [2:0] seg);
    case (seg)
      3'd1:    return 7'd41;
      3'd2:    return 7'd52;
      3'd3:    return 7'd26;
      3'd4:    return 7'd37;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] seg_end(input logic [2:0] seg);
    case (seg)
      3'd0:    return 7'd41;
      3'd1:    return 7'd42;
      3'd2:    return 7'd26;
      3'd3:    return 7'd63;
      3'd4:    return 7'd0;
      3'd5:    return 7'd84;
      default: return 7'd0;
    endcase
  endfunction

  function automatic logic seg_inc(input logic [2:0] seg);
    return (seg == 3'd0) || (seg == 3'd3) || (seg == 3'd5);
  endfunction

  function automatic logic seg_slow(input logic [2:0] seg);
    return (seg == 3'd2) || (seg == 3'd3);
  endfunction

  state_t          state_q, state_d;
  logic [6:0]      x_q, x_d, y_q, y_d;
  logic [2:0]      seg_q, seg_d;
  logic            busy_q, busy_d, done_q, done_d, pulse_q, pulse_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [SW-1:0]   slow_q, slow_d;
  logic [6:0]      active_s;
  logic            step_s;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    seg_d    = seg_q;
    tick_d   = tick_q;
    slow_d   = slow_q;
    pulse_d  = 1'b0;
    step_s   = 1'b0;
    active_s = seg_is_y(seg_q) ? y_q : x_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          seg_d   = 3'd0;
          x_d     = 7'd84;
          y_d     = 7'd0;
          tick_d  = '0;
          slow_d  = '0;
        end
      end
      S_RUN: begin
        // End reached on the previous step: hand over without stepping further.
        if (active_s == seg_end(seg_q)) begin
          state_d = S_LOAD;
        end else begin
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            step_s = 1'b1;
            if (seg_slow(seg_q)) begin
              if (slow_q == SLOW_LAST) begin
                slow_d = '0;
              end else begin
                slow_d = slow_q + 1'b1;
                step_s = 1'b0;
              end
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
          if (step_s) begin
            pulse_d = 1'b1;
            if (seg_is_y(seg_q)) begin
              y_d = seg_inc(seg_q) ? y_q + 7'd1 : y_q - 7'd1;
            end else begin
              x_d = seg_inc(seg_q) ? x_q + 7'd1 : x_q - 7'd1;
            end
          end
        end
      end
      S_LOAD: begin
        tick_d = '0;
        slow_d = '0;
        if (seg_q == 3'd5) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          seg_d   = seg_q + 3'd1;
          x_d     = seg_start_x(seg_q + 3'd1);
          y_d     = seg_start_y(seg_q + 3'd1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_LOAD);
    done_d = (state_d == S_DONE);

    // Unlock gate drops everything back to reset values, overriding start.
    if (!enable) begin
      state_d = S_IDLE;
      x_d     = 7'd84;
      y_d     = 7'd0;
      seg_d   = 3'd0;
      tick_d  = '0;
      slow_d  = '0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      pulse_d = 1'b0;
    end
  end

  always_ff @(posedge sixp25MHz_clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      x_q     <= 7'd84;
      y_q     <= 7'd0;
      seg_q   <= 3'd0;
      tick_q  <= '0;
      slow_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
      slow_q  <= slow_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
    end
  end

  assign var_x      = x_q;
  assign var_y      = y_q;
  assign segment    = seg_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign step_pulse = pulse_q;

endmodule

// File: tb/tb_path_step_generator.sv
// Directed bench for path_step_generator with BASE_DIV=4, SLOW_MULT=3; edge offsets
// are counted from the clock edge that samples start.
module tb_path_step_generator;

  logic       clk = 1'b0;
  logic       reset, enable, start;
  logic [6:0] var_x, var_y;
  logic [2:0] segment;
  logic       busy, done, step_pulse;

  int checks = 0;
  int fails  = 0;
  int now_e  = 0;
  int k      = 0;
  int pulse_cnt = 0;
  int seg_inc_cnt = 0;
  int seg_bad_cnt = 0;
  logic [2:0] last_seg = 3'd0;
  int p0, s0, b0;

  path_step_generator #(.BASE_DIV(4), .SLOW_MULT(3)) dut (
    .sixp25MHz_clock(clk),
    .reset(reset),
    .enable(enable),
    .start(start),
    .var_x(var_x),
    .var_y(var_y),
    .segment(segment),
    .busy(busy),
    .done(done),
    .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  // Count step pulses and segment transitions mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (step_pulse) pulse_cnt++;
    if (segment != last_seg) begin
      if (segment == last_seg + 3'd1) seg_inc_cnt++;
      else if (segment != 3'd0) seg_bad_cnt++;
      last_seg = segment;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
    now_e += n;
  endtask

  task automatic at(input int rel);
    adv(k + rel - now_e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    adv(1);
    start = 1'b0;
    k = now_e;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; start = 1'b0;
    adv(3);
    reset = 1'b0;
    adv(1);
    chk("rst_x", var_x, 84);
    chk("rst_y", var_y, 0);
    chk("rst_seg", segment, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", step_pulse, 0);

    p0 = pulse_cnt;
    adv(1000);
    chk("idle_pulses", pulse_cnt - p0, 0);
    chk("idle_y", var_y, 0);
    chk("idle_busy", busy, 0);

    p0 = pulse_cnt; s0 = seg_inc_cnt; b0 = seg_bad_cnt;
    pulse_start();
    chk("run_busy", busy, 1);
    chk("run_done", done, 0);
    at(3);
    chk("pre_step_y", var_y, 0);
    chk("pre_step_pulse", step_pulse, 0);
    at(4);
    chk("first_step_y", var_y, 1);
    chk("first_step_pulse", step_pulse, 1);
    at(164);
    chk("seg0_end_y", var_y, 41);
    chk("seg0_end_pulse", step_pulse, 1);
    at(165);
    chk("load0_pulse", step_pulse, 0);
    chk("load0_seg", segment, 0);
    chk("load0_busy", busy, 1);
    at(166);
    chk("seg1_seg", segment, 1);
    chk("seg1_x", var_x, 84);
    chk("seg1_y", var_y, 41);

    at(176);
    start = 1'b1;
    at(177);
    start = 1'b0;
    chk("ign_start_seg", segment, 1);
    at(178);
    chk("ign_start_x", var_x, 81);
    chk("ign_start_pulse", step_pulse, 1);
    at(334);
    chk("seg1_end_x", var_x, 42);
    at(336);
    chk("seg2_seg", segment, 2);
    chk("seg2_x", var_x, 42);
    chk("seg2_y", var_y, 52);
    at(347);
    chk("slow_gap_pulse", step_pulse, 0);
    chk("slow_gap_y", var_y, 52);
    at(348);
    chk("slow_step1_y", var_y, 51);
    chk("slow_step1_pulse", step_pulse, 1);
    at(359);
    chk("slow_gap2_pulse", step_pulse, 0);
    at(360);
    chk("slow_step2_y", var_y, 50);
    chk("slow_step2_pulse", step_pulse, 1);
    at(648);
    chk("seg2_end_y", var_y, 26);
    at(650);
    chk("seg3_seg", segment, 3);
    chk("seg3_x", var_x, 42);
    chk("seg3_y", var_y, 26);
    at(904);
    chk("seg4_seg", segment, 4);
    chk("seg4_x", var_x, 63);
    chk("seg4_y", var_y, 37);
    at(1054);
    chk("seg5_seg", segment, 5);
    chk("seg5_x", var_x, 59);
    chk("seg5_y", var_y, 0);
    at(1155);
    chk("last_load_done", done, 0);
    chk("last_load_busy", busy, 1);
    at(1156);
    chk("fin_done", done, 1);
    chk("fin_busy", busy, 0);
    chk("fin_x", var_x, 84);
    chk("fin_y", var_y, 0);
    chk("fin_seg", segment, 5);
    chk("total_pulses", pulse_cnt - p0, 192);
    chk("seg_order_inc", seg_inc_cnt - s0, 5);
    chk("seg_order_bad", seg_bad_cnt - b0, 0);
    adv(20);
    chk("done_hold", done, 1);

    pulse_start();
    chk("restart_done", done, 0);
    chk("restart_busy", busy, 1);
    chk("restart_seg", segment, 0);
    chk("restart_x", var_x, 84);
    chk("restart_y", var_y, 0);
    at(4);
    chk("restart_step_y", var_y, 1);
    at(660);
    chk("mid3_seg", segment, 3);
    enable = 1'b0;
    at(661);
    chk("en_drop_x", var_x, 84);
    chk("en_drop_y", var_y, 0);
    chk("en_drop_seg", segment, 0);
    chk("en_drop_busy", busy, 0);
    chk("en_drop_done", done, 0);

    start = 1'b1;
    adv(1);
    start = 1'b0;
    chk("en_low_start_busy", busy, 0);
    enable = 1'b1;
    p0 = pulse_cnt;
    adv(8);
    chk("post_drop_idle_busy", busy, 0);
    chk("post_drop_idle_pulses", pulse_cnt - p0, 0);

    reset = 1'b1;
    start = 1'b1;
    adv(1);
    reset = 1'b0;
    start = 1'b0;
    chk("rst_start_busy", busy, 0);
    p0 = pulse_cnt;
    adv(8);
    chk("rst_start_idle_busy", busy, 0);
    chk("rst_start_idle_y", var_y, 0);
    chk("rst_start_pulses", pulse_cnt - p0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
